// File: rtl/fifo_burst_reader.sv
// Read-side burst engine: drains a programmed number of words from a synchronous FIFO
// read port and presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 16,
  localparam int unsigned CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic                  fifo_error,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      words_out
);

  localparam logic [CNT_W-1:0] LenMax = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               len_q, len_d;
  logic [CNT_W-1:0]               issued_q, issued_d;
  logic [CNT_W-1:0]               words_q, words_d;
  logic                           err_q, err_d;
  logic                           done_q, done_d;
  logic [1:0]                     occ_q, occ_d;
  logic [1:0][DATA_WIDTH-1:0]     data_q, data_d;  // index 0 is the head entry
  logic [1:0]                     last_q, last_d;

  logic       rd_en;
  logic       hs;
  logic       len_ok;
  logic       start_ok;
  logic       rd_is_last;
  logic [1:0] occ_pop;

  assign len_ok     = (burst_len != '0) && (burst_len <= LenMax);
  assign start_ok   = start && !abort && (state_q == StIdle) && len_ok;
  assign hs         = (occ_q != 2'd0) && m_ready;
  assign rd_is_last = ((issued_q + CNT_W'(1'b1)) == len_q);
  assign occ_pop    = occ_q - {1'b0, hs};

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRead;
      StRead:  if (rd_en && rd_is_last) state_d = StDrain;
      StDrain: if (occ_d == 2'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Outputs; the read strobe is gated by abort so no word is lost from the FIFO.
  always_comb begin
    rd_en      = (state_q == StRead) && (issued_q < len_q) && !fifo_empty &&
                 (occ_q < 2'd2) && !abort;
    fifo_rd_en = rd_en;
    m_valid    = (occ_q != 2'd0);
    m_data     = data_q[0];
    m_last     = last_q[0] && (occ_q != 2'd0);
    busy       = (state_q != StIdle);
    done       = done_q;
    err        = err_q;
    words_out  = words_q;
  end

  // Datapath next-state: counters, sticky error and skid buffer.
  always_comb begin
    len_d    = len_q;
    issued_d = issued_q;
    words_d  = words_q;
    err_d    = err_q;
    data_d   = data_q;
    last_d   = last_q;
    done_d   = hs && last_q[0] && !abort;

    if (start_ok) begin
      len_d    = burst_len;
      issued_d = '0;
      words_d  = '0;
      err_d    = 1'b0;
    end else if (start && !abort) begin
      // Illegal length or start while a burst is running.
      err_d = 1'b1;
    end

    if (rd_en) begin
      issued_d = issued_q + CNT_W'(1'b1);
      if (fifo_error) err_d = 1'b1;
    end

    if (hs && !abort && (words_q < len_q)) words_d = words_q + CNT_W'(1'b1);

    // Pop shifts the tail into the head; a push lands in the first free slot after the pop.
    if (hs) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
    end
    if (rd_en) begin
      if (occ_pop == 2'd0) begin
        data_d[0] = fifo_rd_data;
        last_d[0] = rd_is_last;
      end else begin
        data_d[1] = fifo_rd_data;
        last_d[1] = rd_is_last;
      end
    end
    occ_d = occ_pop + {1'b0, rd_en};
    if (abort) occ_d = 2'd0;
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      len_q    <= '0;
      issued_q <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      occ_q    <= 2'd0;
      data_q   <= '0;
      last_q   <= '0;
    end else begin
      len_q    <= len_d;
      issued_q <= issued_d;
      words_q  <= words_d;
      err_q    <= err_d;
      done_q   <= done_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a behavioural FIFO feeds the DUT, stimulus
// pushes expected words at burst start, and a monitor pops and compares on handshakes.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int CW = 5;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          abort = 1'b0;
  logic          fifo_error = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty, fifo_rd_en, m_valid, m_last, busy, done, err;
  logic [DW-1:0] fifo_rd_data, m_data;
  logic [CW-1:0] words_out;

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_MAX(16)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .burst_len(burst_len), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done), .err(err), .words_out(words_out)
  );

  always #5 CLK = ~CLK;

  // Behavioural FIFO: head word is visible combinationally, popped on a read strobe.
  logic [7:0] mem [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  assign fifo_empty   = (wp == rp);
  assign fifo_rd_data = mem[rp];
  always @(posedge CLK) if (fifo_rd_en) rp <= rp + 8'd1;

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] mdl_q[$];  // words the bench has committed to the FIFO, in order
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_add(input logic [7:0] d);
    mdl_q.push_back(d);
  endtask

  task automatic hw_push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 8'd1;
  endtask

  task automatic push_word(input logic [7:0] d);
    model_add(d);
    hw_push(d);
  endtask

  // acc: the bench's own knowledge of whether this start must be accepted.
  task automatic do_start(input int len, input bit acc);
    burst_len = CW'(len);
    start = 1'b1;
    if (acc) for (int i = 0; i < len; i++) exp_q.push_back({mdl_q.pop_front(), i == len - 1});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("burst_completes_in_budget", 32'(n < budget), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_words_out"}, words_out, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  // Random consumer.
  bit rdy_auto = 1'b0;
  int ready_pct = 100;
  always @(posedge CLK) begin
    #1;
    if (rdy_auto) m_ready = ($urandom_range(0, 99) < 32'(ready_pct));
  end

  // Monitor: sampled mid-cycle, values are those seen by the next rising edge.
  bit         prev_hold = 1'b0;
  bit         prev_last_hs = 1'b0;
  logic [7:0] prev_d;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      prev_hold    = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_m_valid", m_valid, 1);
        chk("hold_m_data", m_data, prev_d);
      end
      chk("done_after_last", done, prev_last_hs);
      if (fifo_rd_en) begin
        chk("rd_en_while_empty", fifo_empty, 0);
        chk("rd_en_while_idle", busy, 1);
      end
      prev_last_hs = 1'b0;
      if (m_valid && m_ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
        end
        prev_last_hs = m_last;
      end
      prev_hold = m_valid && !m_ready && !abort;
      prev_d    = m_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] buf_d [16];
    int len, pre;
    repeat (3) tick();
    chk_all_zero("reset");
    RESET = 1'b0;
    tick();

    // 1: back-to-back reads with consumer always ready.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    do_start(4, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_en_b2b", fifo_rd_en, 1);
      tick();
    end
    chk("t1_rd_en_off", fifo_rd_en, 0);
    wait_idle(50);
    chk("t1_words_out", words_out, 4);
    chk("t1_err", err, 0);

    // 2: backpressure stops reads at two words.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    do_start(4, 1);
    repeat (5) tick();
    chk("t2_fifo_left", 32'(8'(wp - rp)), 2);
    chk("t2_head_data", m_data, 8'h11);
    chk("t2_m_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_idle(50);
    chk("t2_words_out", words_out, 4);

    // 3: underrun stalls, no error.
    rdy_auto = 1'b1;
    ready_pct = 70;
    for (int i = 0; i < 3; i++) model_add(8'hA0 + 8'(i));
    do_start(3, 1);
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick();
      hw_push(8'hA0 + 8'(i));
    end
    wait_idle(100);
    chk("t3_err", err, 0);
    chk("t3_words_out", words_out, 3);

    // 4: illegal lengths set err, a legal start clears it.
    rdy_auto = 1'b0;
    m_ready = 1'b1;
    do_start(0, 0);
    chk("t4_len0_busy", busy, 0);
    chk("t4_len0_err", err, 1);
    do_start(17, 0);
    chk("t4_len17_busy", busy, 0);
    chk("t4_len17_err", err, 1);
    push_word(8'h31);
    push_word(8'h32);
    do_start(2, 1);
    chk("t4_err_cleared", err, 0);
    chk("t4_busy", busy, 1);
    wait_idle(50);
    chk("t4_words_out", words_out, 2);

    // start and abort together: abort wins, no error even for an illegal length.
    burst_len = '0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_err", err, 0);

    // start while busy is ignored and flagged; burst completes.
    rdy_auto = 1'b1;
    ready_pct = 50;
    for (int i = 0; i < 6; i++) push_word(8'h40 + 8'(i));
    do_start(6, 1);
    tick();
    do_start(3, 0);
    chk("busy_start_err", err, 1);
    wait_idle(100);
    chk("busy_start_words", words_out, 6);

    // 5: abort after three handshakes.
    rdy_auto = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h51 + 8'(i));
    do_start(8, 1);
    repeat (3) tick();
    m_ready = 1'b1;
    repeat (3) tick();
    m_ready = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_words_out", words_out, 3);
    chk("t5_fifo_left", 32'(8'(wp - rp)), 3);
    // Three handshaked plus two skid entries were read; the rest is still in the FIFO.
    for (int i = exp_q.size() - 1; i >= 2; i--) mdl_q.push_front(exp_q[i].d);
    exp_q.delete();
    rdy_auto = 1'b1;
    ready_pct = 60;
    do_start(3, 1);
    wait_idle(100);
    chk("t5_resume_words", words_out, 3);

    // 6: asynchronous reset mid-burst.
    rdy_auto = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(8'h60 + 8'(i));
    do_start(16, 1);
    repeat (4) tick();
    #2 RESET = 1'b1;
    #1 chk_all_zero("t6_async");
    tick();
    tick();
    chk("t6_rd_en_held", fifo_rd_en, 0);
    chk("t6_fifo_left", 32'(8'(wp - rp)), 14);
    RESET = 1'b0;
    for (int i = exp_q.size() - 1; i >= 2; i--) mdl_q.push_front(exp_q[i].d);
    exp_q.delete();
    push_word(8'h70);
    push_word(8'h71);
    rdy_auto = 1'b1;
    ready_pct = 80;
    do_start(16, 1);
    wait_idle(300);
    chk("t6_words_out", words_out, 16);

    // fifo_error during reads sets the sticky flag, burst still completes.
    for (int i = 0; i < 3; i++) push_word(8'h80 + 8'(i));
    fifo_error = 1'b1;
    do_start(3, 1);
    wait_idle(100);
    fifo_error = 1'b0;
    chk("fifo_error_err", err, 1);
    chk("fifo_error_words", words_out, 3);

    // Randomized bursts with partial prefill, data arriving during the burst.
    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(1, 16);
      pre = $urandom_range(0, len);
      ready_pct = $urandom_range(20, 100);
      for (int i = 0; i < len; i++) begin
        buf_d[i] = 8'($urandom);
        model_add(buf_d[i]);
      end
      for (int i = 0; i < pre; i++) hw_push(buf_d[i]);
      do_start(len, 1);
      for (int i = pre; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        hw_push(buf_d[i]);
      end
      wait_idle(400);
      chk("rand_words_out", words_out, 32'(len));
      chk("rand_err", err, 0);
    end

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
